// File: rtl/mat_mult_seq.sv
// Address/control sequencer for the NxN matrix-multiply datapath: walks i/j/k, drives operand
// reads, MAC clear/enable and C write-back. Optional abort input under `MAT_SEQ_ABORT_EN`.
module mat_mult_seq #(
  parameter int unsigned N      = 8,
  parameter int unsigned AW     = 6,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
`ifdef MAT_SEQ_ABORT_EN
  input  logic          abort,
`endif
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] a_addr,
  output logic [AW-1:0] b_addr,
  output logic          rd_en,
  output logic          mac_clr,
  output logic          mac_en,
  output logic [AW-1:0] c_addr,
  output logic          c_we,
  output logic [15:0]   cycle_count
);

  localparam int unsigned LW = $clog2(N);
  localparam int unsigned DW = 3;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  typedef struct packed {
    logic          valid;
    logic          first;
    logic          last;
    logic [AW-1:0] addr;
  } pipe_t;

  state_e               state_q, state_d;
  logic [LW-1:0]        i_q, i_d, j_q, j_d, k_q, k_d;
  logic [DW-1:0]        drain_q, drain_d;
  logic [15:0]          cc_q, cc_d;
  pipe_t [RD_LAT-1:0]   pipe_q, pipe_d;
  pipe_t                issue, pipe_out;
  logic                 c_we_q, c_we_d;
  logic [AW-1:0]        c_addr_q, c_addr_d;
  logic                 k_max, j_max, i_max;

  assign k_max    = (k_q == {LW{1'b1}});
  assign j_max    = (j_q == {LW{1'b1}});
  assign i_max    = (i_q == {LW{1'b1}});
  assign pipe_out = pipe_q[RD_LAT-1];

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    drain_d  = drain_q;
    cc_d     = cc_q;

    issue.valid = (state_q == StRun);
    issue.first = (k_q == '0);
    issue.last  = k_max;
    issue.addr  = {i_q, j_q};

    pipe_d[0] = issue;
    for (int s = 1; s < RD_LAT; s++) begin
      pipe_d[s] = pipe_q[s-1];
    end

    // Write stage sits one register behind the MAC enable.
    c_we_d   = pipe_out.valid & pipe_out.last;
    c_addr_d = c_we_d ? pipe_out.addr : c_addr_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          cc_d    = '0;
        end
      end
      StRun: begin
        cc_d = (cc_q == 16'hFFFF) ? cc_q : cc_q + 16'd1;
        k_d  = k_q + LW'(1);
        if (k_max) begin
          j_d = j_q + LW'(1);
          if (j_max) begin
            i_d = i_q + LW'(1);
            if (i_max) begin
              state_d = StDrain;
              drain_d = '0;
            end
          end
        end
      end
      StDrain: begin
        cc_d = (cc_q == 16'hFFFF) ? cc_q : cc_q + 16'd1;
        if (drain_q == DW'(RD_LAT)) begin
          state_d = StDone;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      StDone: begin
        if (!start) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

`ifdef MAT_SEQ_ABORT_EN
    // Abort flushes in-flight operands so nothing reaches the MAC or result RAM.
    if (abort && (state_q == StRun || state_q == StDrain)) begin
      state_d  = StIdle;
      i_d      = '0;
      j_d      = '0;
      k_d      = '0;
      pipe_d   = '0;
      c_we_d   = 1'b0;
      c_addr_d = c_addr_q;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      drain_q  <= '0;
      cc_q     <= '0;
      pipe_q   <= '0;
      c_we_q   <= 1'b0;
      c_addr_q <= '0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      drain_q  <= drain_d;
      cc_q     <= cc_d;
      pipe_q   <= pipe_d;
      c_we_q   <= c_we_d;
      c_addr_q <= c_addr_d;
    end
  end

  assign busy        = (state_q == StRun) || (state_q == StDrain);
  assign done        = (state_q == StDone);
  assign rd_en       = (state_q == StRun);
  assign a_addr      = {i_q, k_q};
  assign b_addr      = {k_q, j_q};
  assign mac_en      = pipe_out.valid;
  assign mac_clr     = pipe_out.valid & pipe_out.first;
  assign c_we        = c_we_q;
  assign c_addr      = c_addr_q;
  assign cycle_count = cc_q;

endmodule

// File: tb/tb_mat_mult_seq.sv
// Directed bench for mat_mult_seq: default instance (RD_LAT=1) plus an RD_LAT=3 instance.
module tb_mat_mult_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, start3;
`ifdef MAT_SEQ_ABORT_EN
  logic abort;
`endif

  logic       busy, done, rd_en, mac_clr, mac_en, c_we;
  logic [5:0] a_addr, b_addr, c_addr;
  logic [15:0] cycle_count;
  logic       busy3, done3, rd_en3, mac_clr3, mac_en3, c_we3;
  logic [5:0] a_addr3, b_addr3, c_addr3;
  logic [15:0] cycle_count3;

  mat_mult_seq dut (
    .clk(clk), .reset(reset),
`ifdef MAT_SEQ_ABORT_EN
    .abort(abort),
`endif
    .start(start), .busy(busy), .done(done), .a_addr(a_addr), .b_addr(b_addr),
    .rd_en(rd_en), .mac_clr(mac_clr), .mac_en(mac_en), .c_addr(c_addr), .c_we(c_we),
    .cycle_count(cycle_count)
  );

  mat_mult_seq #(.N(8), .AW(6), .RD_LAT(3)) dut3 (
    .clk(clk), .reset(reset),
`ifdef MAT_SEQ_ABORT_EN
    .abort(abort),
`endif
    .start(start3), .busy(busy3), .done(done3), .a_addr(a_addr3), .b_addr(b_addr3),
    .rd_en(rd_en3), .mac_clr(mac_clr3), .mac_en(mac_en3), .c_addr(c_addr3), .c_we(c_we3),
    .cycle_count(cycle_count3)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic quiet();
    return ({busy, done, rd_en, mac_clr, mac_en, c_we, a_addr, b_addr, c_addr,
             cycle_count} == '0);
  endfunction

  function automatic logic quiet3();
    return ({busy3, done3, rd_en3, mac_clr3, mac_en3, c_we3, a_addr3, b_addr3, c_addr3,
             cycle_count3} == '0);
  endfunction

  localparam int NCAP = 560;
  logic [5:0]  la[NCAP], lb[NCAP], lc[NCAP];
  logic        lrd[NCAP], len[NCAP], lclr[NCAP], lwe[NCAP], lbusy[NCAP], ldone[NCAP];
  logic [15:0] lcc[NCAP];

  task automatic sample(input int n);
    la[n] = a_addr; lb[n] = b_addr; lc[n] = c_addr;
    lrd[n] = rd_en; len[n] = mac_en; lclr[n] = mac_clr; lwe[n] = c_we;
    lbusy[n] = busy; ldone[n] = done; lcc[n] = cycle_count;
  endtask

  typedef struct {
    int          cyc;
    logic [5:0]  a, b;
    logic        rd, en, clr, we;
    logic [5:0]  ca;
    logic        bsy, dn;
    logic [15:0] cc;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int n_rd, n_we, n_clr, n_en, order_err, overlap, clr_no_en, first_we, first_done;
    int next_c, writes, f_en, f_we, f_done, cc_done, bad;
    logic [63:0] act, exp;

    // cyc: a b rd en clr we c_addr busy done cycle_count (cycle index Tn, T0 = start seen)
    vecs[0]  = '{0,   6'd0,  6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 16'd0};
    vecs[1]  = '{1,   6'd0,  6'd0,  1'b1, 1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 1'b0, 16'd0};
    vecs[2]  = '{2,   6'd1,  6'd8,  1'b1, 1'b1, 1'b1, 1'b0, 6'd0,  1'b1, 1'b0, 16'd1};
    vecs[3]  = '{3,   6'd2,  6'd16, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0,  1'b1, 1'b0, 16'd2};
    vecs[4]  = '{10,  6'd1,  6'd9,  1'b1, 1'b1, 1'b1, 1'b1, 6'd0,  1'b1, 1'b0, 16'd9};
    vecs[5]  = '{11,  6'd2,  6'd17, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0,  1'b1, 1'b0, 16'd10};
    vecs[6]  = '{18,  6'd1,  6'd10, 1'b1, 1'b1, 1'b1, 1'b1, 6'd1,  1'b1, 1'b0, 16'd17};
    vecs[7]  = '{78,  6'd13, 6'd41, 1'b1, 1'b1, 1'b0, 1'b0, 6'd8,  1'b1, 1'b0, 16'd77};
    vecs[8]  = '{512, 6'd63, 6'd63, 1'b1, 1'b1, 1'b0, 1'b0, 6'd62, 1'b1, 1'b0, 16'd511};
    vecs[9]  = '{513, 6'd0,  6'd0,  1'b0, 1'b1, 1'b0, 1'b0, 6'd62, 1'b1, 1'b0, 16'd512};
    vecs[10] = '{514, 6'd0,  6'd0,  1'b0, 1'b0, 1'b0, 1'b1, 6'd63, 1'b1, 1'b0, 16'd513};
    vecs[11] = '{515, 6'd0,  6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 6'd63, 1'b0, 1'b1, 16'd514};
    vecs[12] = '{540, 6'd0,  6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 6'd63, 1'b0, 1'b1, 16'd514};

    reset = 1'b1; start = 1'b0; start3 = 1'b0;
`ifdef MAT_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("reset_outputs", {63'd0, quiet() & quiet3()}, 64'd1);
    reset = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!quiet() || !quiet3()) bad++;
    end
    chk("idle_quiet", bad, 0);

    // Full default run, start held high throughout.
    sample(0);
    start = 1'b1;
    for (int n = 1; n < NCAP; n++) begin
      @(negedge clk);
      sample(n);
    end
    foreach (vecs[v]) begin
      int c;
      c = vecs[v].cyc;
      act = {22'd0, la[c], lb[c], lrd[c], len[c], lclr[c], lwe[c], lc[c], lbusy[c], ldone[c],
             lcc[c]};
      exp = {22'd0, vecs[v].a, vecs[v].b, vecs[v].rd, vecs[v].en, vecs[v].clr, vecs[v].we,
             vecs[v].ca, vecs[v].bsy, vecs[v].dn, vecs[v].cc};
      chk($sformatf("vec_T%0d", c), act, exp);
    end
    n_rd = 0; n_we = 0; n_clr = 0; n_en = 0; order_err = 0; overlap = 0; clr_no_en = 0;
    first_we = -1; first_done = -1; next_c = 0;
    for (int n = 1; n < NCAP; n++) begin
      if (lrd[n]) n_rd++;
      if (len[n]) n_en++;
      if (lclr[n]) n_clr++;
      if (lclr[n] && !len[n]) clr_no_en++;
      if (lbusy[n] && ldone[n]) overlap++;
      if (ldone[n] && first_done < 0) first_done = n;
      if (lwe[n]) begin
        if (first_we < 0) first_we = n;
        if (int'(lc[n]) != next_c) order_err++;
        next_c++;
        n_we++;
      end
    end
    chk("rd_en_count", n_rd, 512);
    chk("mac_en_count", n_en, 512);
    chk("mac_clr_count", n_clr, 64);
    chk("mac_clr_without_en", clr_no_en, 0);
    chk("c_we_count", n_we, 64);
    chk("c_addr_order", order_err, 0);
    chk("first_c_we_cycle", first_we, 10);
    chk("first_done_cycle", first_done, 515);
    chk("busy_done_overlap", overlap, 0);

    start = 1'b0;
    @(negedge clk);
    chk("done_to_idle", {busy, done}, 2'b00);

    // Reset in the middle of a run, then a clean restart.
    start = 1'b1;
    repeat (201) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrun_reset_quiet", {63'd0, quiet()}, 64'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("restart_T1", {rd_en, a_addr, b_addr}, {1'b1, 6'd0, 6'd0});
    writes = 0; f_done = 0;
    for (int n = 0; n < 700 && !done; n++) begin
      if (c_we) writes++;
      @(negedge clk);
    end
    chk("restart_done", done, 1'b1);
    chk("restart_writes", writes, 64);
    start = 1'b0;
    @(negedge clk);

    // RD_LAT=3 instance.
    start3 = 1'b1;
    f_en = -1; f_we = -1; f_done = -1; cc_done = 0;
    for (int n = 1; n < 700 && f_done < 0; n++) begin
      @(negedge clk);
      if (mac_en3 && f_en < 0) f_en = n;
      if (c_we3 && f_we < 0) f_we = n;
      if (done3) begin
        f_done = n;
        cc_done = cycle_count3;
      end
    end
    chk("lat3_first_mac_en", f_en, 4);
    chk("lat3_first_c_we", f_we, 12);
    chk("lat3_done_cycle", f_done, 517);
    chk("lat3_cycle_count", cc_done, 516);
    start3 = 1'b0;
    @(negedge clk);

`ifdef MAT_SEQ_ABORT_EN
    // Abort sampled during T101; nothing may follow it.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_to_idle", {busy, done}, 2'b00);
    bad = 0;
    repeat (60) begin
      if (c_we || mac_en || done || busy) bad++;
      @(negedge clk);
    end
    chk("abort_silent", bad, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("abort_restart_T1", {rd_en, a_addr}, {1'b1, 6'd0});
    writes = 0;
    for (int n = 0; n < 700 && !done; n++) begin
      if (c_we) writes++;
      @(negedge clk);
    end
    chk("abort_restart_done", done, 1'b1);
    chk("abort_restart_writes", writes, 64);
    @(negedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
